// File: rtl/folded_maj_pkg.sv
// Shared types and constant helpers for the folded majority counter.
package folded_maj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/folded_maj_seq_if.sv
// Beat-in / result-out bus of the folded majority counter.
interface folded_maj_seq_if
    import folded_maj_pkg::*;
#(
    parameter int N = 67,
    parameter int W = 8
) ();
    localparam int CW = clog2(N + 1);

    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid && ready; the sender holds its payload stable until that edge.
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [CW-1:0] thresh;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic          y;
    logic [CW-1:0] count;
    logic          tie;

    modport master (
        output in_valid, in_data, thresh, abort, out_ready,
        input  in_ready, out_valid, y, count, tie
    );

    modport slave (
        input  in_valid, in_data, thresh, abort, out_ready,
        output in_ready, out_valid, y, count, tie
    );
endinterface

// File: rtl/folded_maj_seq_chunk_popcount.sv
// Combinational ones-count of one W-bit beat.
module chunk_popcount
    import folded_maj_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]            bits,
    output logic [clog2(W+1)-1:0]   ones
);
    localparam int PW = clog2(W + 1);

    always_comb begin
        ones = '0;
        for (int i = 0; i < W; i++) begin
            ones = ones + PW'(bits[i]);
        end
    end
endmodule

// File: rtl/folded_maj_seq.sv
// Folded majority/threshold detector: accumulates the ones-count of an N-bit
// vector delivered W bits per beat and reports count, y = count >= threshold, tie.
module folded_maj_seq
    import folded_maj_pkg::*;
#(
    parameter int N = 67,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    folded_maj_seq_if.slave      bus,
    output logic [1:0]           state_dbg
);
    localparam int NB  = (N + W - 1) / W;
    localparam int CW  = clog2(N + 1);
    localparam int PW  = clog2(W + 1);
    localparam int BIW = (NB > 1) ? clog2(NB) : 1;
    localparam int MAJ = (N + 1) / 2;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ACC  = ST_ACC;
    localparam logic [1:0] DONE = ST_DONE;

    // Bits of the final beat that lie beyond vector bit N-1 are padding.
    function automatic logic [W-1:0] last_mask();
        logic [W-1:0] m;
        for (int i = 0; i < W; i++) begin
            m[i] = (((NB - 1) * W + i) < N);
        end
        return m;
    endfunction
    localparam logic [W-1:0] LAST_MASK = last_mask();

    logic [1:0]     state;
    logic [CW-1:0]  acc;
    logic [BIW-1:0] beat_idx;
    logic [CW-1:0]  thresh_q;
    logic           y_q;
    logic [CW-1:0]  count_q;
    logic           tie_q;

    logic           in_ready;
    logic           xfer;
    logic           is_last;
    logic [W-1:0]   beat_bits;
    logic [PW-1:0]  beat_ones;
    logic [CW-1:0]  acc_sum;
    logic [CW-1:0]  thr_raw;
    logic [CW-1:0]  thr_eff;

    assign in_ready  = (state != DONE);
    assign xfer      = bus.in_valid && in_ready;
    assign is_last   = (beat_idx == BIW'(NB - 1));
    assign beat_bits = is_last ? (bus.in_data & LAST_MASK) : bus.in_data;

    chunk_popcount #(.W(W)) u_chunk_popcount (
        .bits (beat_bits),
        .ones (beat_ones)
    );

    // First beat starts from zero so a stale accumulator can never leak in.
    assign acc_sum = ((state == IDLE) ? '0 : acc) + CW'(beat_ones);
    assign thr_raw = (state == IDLE) ? bus.thresh : thresh_q;
    assign thr_eff = (thr_raw == '0) ? CW'(MAJ) : thr_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            beat_idx <= '0;
            thresh_q <= '0;
            y_q      <= 1'b0;
            count_q  <= '0;
            tie_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (bus.abort) begin
                        state    <= IDLE;
                        acc      <= '0;
                        beat_idx <= '0;
                    end else if (xfer) begin
                        acc <= acc_sum;
                        if (state == IDLE) thresh_q <= bus.thresh;
                        if (is_last) begin
                            state    <= DONE;
                            beat_idx <= '0;
                            count_q  <= acc_sum;
                            y_q      <= (acc_sum >= thr_eff);
                            tie_q    <= ({acc_sum, 1'b0} == (CW + 1)'(N));
                        end else begin
                            state    <= ACC;
                            beat_idx <= beat_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                        acc   <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    acc      <= '0;
                    beat_idx <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_q;
    assign bus.count     = count_q;
    assign bus.tie       = tie_q;
    assign state_dbg     = state;

endmodule

// File: tb/tb_folded_maj_seq.sv
// Self-checking bench for folded_maj_seq with a popcount reference model.
module tb_folded_maj_seq;
    localparam int N  = 67;
    localparam int W  = 8;
    localparam int NB = 9;
    localparam int CW = 7;
    localparam int VW = NB * W;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected results packed as {y, tie, count}.
    logic [CW+1:0] exp_q[$];

    folded_maj_seq_if #(.N(N), .W(W)) bus ();

    folded_maj_seq #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_ones(input logic [VW-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic logic [CW+1:0] ref_result(input logic [VW-1:0] v, input int thr);
        int   c;
        int   t;
        logic yv;
        logic tv;
        logic [CW-1:0] cv;
        c  = ref_ones(v);
        t  = (thr == 0) ? (N + 1) / 2 : thr;
        yv = (c >= t);
        tv = (2 * c == N);
        cv = c[CW-1:0];
        return {yv, tv, cv};
    endfunction

    // Random vector with exactly k ones in bits 0..N-1 and random padding.
    function automatic logic [VW-1:0] vec_with_ones(input int k);
        logic [VW-1:0] v;
        int pos;
        int c;
        v = '0;
        v[VW-1:N] = (VW - N)'($urandom);
        c = 0;
        while (c < k) begin
            pos = $urandom_range(0, N - 1);
            if (!v[pos]) begin
                v[pos] = 1'b1;
                c++;
            end
        end
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [W-1:0] d, input logic [CW-1:0] thr,
                              input logic ab, output bit ok);
        bit rdy;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.thresh   = thr;
        bus.abort    = ab;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) ok = 1;
        end
        #1;
        bus.in_valid = 1'b0;
        bus.abort    = 1'b0;
    endtask

    task automatic send_vector(input logic [VW-1:0] v, input logic [CW-1:0] thr,
                               input int max_gap);
        bit ok;
        for (int k = 0; k < NB; k++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            drive_beat(v[k*W +: W], thr, 1'b0, ok);
            if (!ok) begin
                n_cmp++;
                n_bad++;
                $display("FAIL beat_accept: beat %0d not accepted within budget", k);
            end
        end
    endtask

    task automatic take_result(input int hold, output logic [CW+1:0] got, output bit seen);
        seen = 0;
        got  = '0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        if (seen) begin
            got = {bus.y, bus.tie, bus.count};
            repeat (hold) @(negedge clk);
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.thresh    = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.y, bus.tie, bus.count} !== {1'b1, 1'b0, 1'b0, 1'b0, 7'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b ov=%b y=%b tie=%b cnt=%0d, want rdy=1 ov=0 y=0 tie=0 cnt=0",
                     bus.in_ready, bus.out_valid, bus.y, bus.tie, bus.count);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_ones();
        logic [VW-1:0] v;
        logic [CW+1:0] got;
        logic [CW+1:0] exp;
        bit ok;
        bit seen;
        v = '1;
        for (int k = 0; k < NB - 1; k++) drive_beat(v[k*W +: W], 7'd0, 1'b0, ok);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL early_valid: got out_valid=%b before last beat, want 0", bus.out_valid);
        end
        drive_beat(v[(NB-1)*W +: W], 7'd0, 1'b0, ok);
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL result_latency: got out_valid=%b one cycle after last beat, want 1", bus.out_valid);
        end
        exp = {1'b1, 1'b0, 7'd67};
        take_result(0, got, seen);
        n_cmp++;
        if (!seen || got !== exp) begin
            n_bad++;
            $display("FAIL all_ones: got {y,tie,cnt}=%b/%b/%0d seen=%0d, want 1/0/67",
                     got[CW+1], got[CW], got[CW-1:0], seen);
        end
    endtask

    task automatic test_majority_edge();
        logic [VW-1:0] v;
        logic [CW+1:0] got;
        bit seen;
        for (int k = 33; k <= 34; k++) begin
            v = vec_with_ones(k);
            exp_q.push_back(ref_result(v, 0));
            send_vector(v, 7'd0, 1);
            take_result($urandom_range(0, 2), got, seen);
            n_cmp++;
            if (!seen || got !== exp_q[0]) begin
                n_bad++;
                $display("FAIL majority_%0d: got %b seen=%0d want %b", k, got, seen, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_mask();
        logic [VW-1:0] v;
        logic [CW+1:0] got;
        bit seen;
        v = '0;
        v[VW-1 -: W] = 8'hFF;
        exp_q.push_back({1'b0, 1'b0, 7'd3});
        send_vector(v, 7'd0, 0);
        take_result(0, got, seen);
        n_cmp++;
        if (!seen || got !== exp_q[0]) begin
            n_bad++;
            $display("FAIL last_beat_mask: got y=%b cnt=%0d want y=0 cnt=3", got[CW+1], got[CW-1:0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_thresh();
        logic [VW-1:0] v;
        logic [CW+1:0] got;
        bit seen;
        int thr_tab[4];
        int ones_tab[4];
        thr_tab  = '{10, 11, 67, 68};
        ones_tab = '{10, 10, 67, 67};
        for (int t = 0; t < 4; t++) begin
            v = (ones_tab[t] == N) ? '1 : vec_with_ones(ones_tab[t]);
            exp_q.push_back(ref_result(v, thr_tab[t]));
            send_vector(v, CW'(thr_tab[t]), 1);
            take_result(1, got, seen);
            n_cmp++;
            if (!seen || got !== exp_q[0]) begin
                n_bad++;
                $display("FAIL thresh_%0d: got %b seen=%0d want %b", thr_tab[t], got, seen, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v;
        logic [CW+1:0] exp;
        logic [CW+1:0] got;
        bit seen;
        int bad;
        v   = vec_with_ones($urandom_range(20, 50));
        exp = ref_result(v, 0);
        send_vector(v, 7'd0, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                {bus.y, bus.tie, bus.count} !== exp) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL backpressure_hold: %0d bad cycles, last rdy=%b ov=%b res=%b want rdy=0 ov=1 res=%b",
                     bad, bus.in_ready, bus.out_valid, {bus.y, bus.tie, bus.count}, exp);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.out_valid, bus.in_ready, bus.y, bus.tie, bus.count} !== {1'b0, 1'b1, exp}) begin
            n_bad++;
            $display("FAIL release: got ov=%b rdy=%b res=%b want ov=0 rdy=1 res=%b",
                     bus.out_valid, bus.in_ready, {bus.y, bus.tie, bus.count}, exp);
        end
        v   = vec_with_ones(12);
        exp = ref_result(v, 0);
        @(posedge clk);
        #1;
        send_vector(v, 7'd0, 0);
        take_result(0, got, seen);
        n_cmp++;
        if (!seen || got !== exp) begin
            n_bad++;
            $display("FAIL no_beat_consumed: got %b want %b", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [CW+1:0] got;
        bit ok;
        bit seen;
        for (int k = 0; k < 4; k++) drive_beat(8'hFF, 7'd0, 1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.y, bus.tie, bus.count, bus.in_ready} !== {1'b0, 1'b0, 1'b0, 7'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL mid_reset_clear: got ov=%b y=%b tie=%b cnt=%0d rdy=%b want 0/0/0/0/1",
                     bus.out_valid, bus.y, bus.tie, bus.count, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_vector('1, 7'd0, 1);
        take_result(0, got, seen);
        n_cmp++;
        if (!seen || got !== {1'b1, 1'b0, 7'd67}) begin
            n_bad++;
            $display("FAIL after_reset_count: got cnt=%0d seen=%0d want 67", got[CW-1:0], seen);
        end
    endtask

    task automatic test_abort();
        logic [CW+1:0] got;
        bit ok;
        bit seen;
        int early;
        for (int k = 0; k < 4; k++) drive_beat(8'hFF, 7'd0, 1'b0, ok);
        drive_beat(8'hFF, 7'd0, 1'b1, ok);
        early = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) early++;
        end
        for (int k = 0; k < 4; k++) drive_beat(8'hFF, 7'd0, 1'b0, ok);
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) early++;
        end
        n_cmp++;
        if (early != 0) begin
            n_bad++;
            $display("FAIL abort_no_result: out_valid seen %0d cycles, want 0", early);
        end
        @(posedge clk);
        #1;
        for (int k = 4; k < NB; k++) drive_beat(8'hFF, 7'd0, 1'b0, ok);
        take_result(0, got, seen);
        n_cmp++;
        if (!seen || got !== {1'b1, 1'b0, 7'd67}) begin
            n_bad++;
            $display("FAIL after_abort_count: got cnt=%0d seen=%0d want 67", got[CW-1:0], seen);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] v;
        logic [CW+1:0] got;
        bit seen;
        int thr;
        for (int n = 0; n < 25; n++) begin
            v = {$urandom, $urandom, $urandom};
            if (n % 5 == 0) v = vec_with_ones($urandom_range(0, N));
            thr = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 80);
            exp_q.push_back(ref_result(v, thr));
            send_vector(v, CW'(thr), 2);
            take_result($urandom_range(0, 3), got, seen);
            n_cmp++;
            if (!seen || got !== exp_q[0]) begin
                n_bad++;
                $display("FAIL random_%0d: got %b seen=%0d want %b (thr %0d)", n, got, seen, exp_q[0], thr);
            end
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_ones();
        test_majority_edge();
        test_mask();
        test_thresh();
        test_backpressure();
        test_reset_mid();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
